// File: rtl/ysyx_24110006_clint_pkg.sv
// ysyx_24110006_clint shared types: register offsets, response codes, FSM state.
// Optional feature macro: CLINT_SNAPSHOT_EN (atomic hi/lo mtime pair read).
package ysyx_24110006_clint_pkg;

  localparam logic [31:0] MTIME_LO_OFF = 32'h0;
  localparam logic [31:0] MTIME_HI_OFF = 32'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } clint_rd_t;

  function automatic clint_rd_t rd_pack(
    input logic [31:0] data,
    input logic [1:0]  resp
  );
    clint_rd_t r;
    r.data = data;
    r.resp = resp;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_24110006_clint_if.sv
// AXI-lite read-only channel pair between the crossbar and the CLINT.
// Optional feature macro: CLINT_SNAPSHOT_EN (no effect on this file).
interface ysyx_24110006_clint_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output araddr,
    output arvalid,
    output rready,
    input  arready,
    input  rdata,
    input  rvalid,
    input  rresp
  );

  modport slave (
    input  araddr,
    input  arvalid,
    input  rready,
    output arready,
    output rdata,
    output rvalid,
    output rresp
  );

endinterface

// File: rtl/ysyx_24110006_clint_timer.sv
// Free-running 64-bit mtime with a 0..TICK_DIV-1 prescaler.
// Optional feature macro: CLINT_SNAPSHOT_EN (no effect on this file).
module ysyx_24110006_clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [63:0] o_mtime
);

  logic [63:0] r_mtime;
  logic        w_tick;

  generate
    if (TICK_DIV <= 1) begin : g_nodiv
      assign w_tick = 1'b1;
    end else begin : g_div
      localparam logic [15:0] LAST = 16'(TICK_DIV - 1);
      logic [15:0] r_pre;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_pre <= '0;
        end else if (r_pre == LAST) begin
          r_pre <= '0;
        end else begin
          r_pre <= r_pre + 16'd1;
        end
      end

      assign w_tick = (r_pre == LAST);
    end
  endgenerate

  // wraps silently at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mtime <= '0;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/ysyx_24110006_clint.sv
// Read-only CLINT: AXI read FSM and mtime lo/hi decode over the timer.
// Optional feature macro: CLINT_SNAPSHOT_EN latches mtime[63:32] on lo reads.
module ysyx_24110006_clint
  import ysyx_24110006_clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  output logic [1:0]  o_axi_rresp,
  input  logic        i_axi_rready
);

  clint_state_e r_state;
  clint_state_e w_next;
  logic         r_live;
  logic         w_ar_hs;
  logic         w_r_hs;
  logic         w_sel_lo;
  logic         w_sel_hi;
  logic [63:0]  w_mtime;
  logic [31:0]  w_hi_word;
  clint_rd_t    w_rd;
  logic [31:0]  r_rdata;
  logic [1:0]   r_rresp;

  ysyx_24110006_clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_mtime (w_mtime)
  );

  // keeps arready low until the first edge after reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_ar_hs) w_next = RESP;
      RESP: if (w_r_hs)  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_axi_arready = 1'b0;
    o_axi_rvalid  = 1'b0;
    unique case (r_state)
      IDLE: o_axi_arready = r_live;
      RESP: o_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  assign w_ar_hs  = i_axi_arvalid & o_axi_arready;
  assign w_r_hs   = o_axi_rvalid & i_axi_rready;
  assign w_sel_lo = (i_axi_araddr == BASE_ADDR + MTIME_LO_OFF);
  assign w_sel_hi = (i_axi_araddr == BASE_ADDR + MTIME_HI_OFF);

`ifdef CLINT_SNAPSHOT_EN
  logic [31:0] r_shadow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (w_ar_hs && w_sel_lo) begin
      r_shadow <= w_mtime[63:32];
    end
  end

  assign w_hi_word = r_shadow;
`else
  assign w_hi_word = w_mtime[63:32];
`endif

  always_comb begin
    w_rd = rd_pack(32'h0, RESP_SLVERR);
    unique case (1'b1)
      w_sel_lo: w_rd = rd_pack(w_mtime[31:0], RESP_OKAY);
      w_sel_hi: w_rd = rd_pack(w_hi_word, RESP_OKAY);
      default: ;
    endcase
  end

  // captured pre-increment value, held through any rready stall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd.data;
      r_rresp <= w_rd.resp;
    end
  end

  assign o_axi_rdata = r_rdata;
  assign o_axi_rresp = r_rresp;

endmodule

// File: tb/tb_ysyx_24110006_clint.sv
// Directed bench for ysyx_24110006_clint: TICK_DIV=1 and TICK_DIV=4 instances.
// Expectations follow CLINT_SNAPSHOT_EN when it is defined for the build.
module tb_ysyx_24110006_clint;
  import ysyx_24110006_clint_pkg::*;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_24110006_clint_if b0();
  ysyx_24110006_clint_if b1();

  ysyx_24110006_clint #(
    .BASE_ADDR (BASE),
    .TICK_DIV  (1)
  ) u_dut0 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_axi_araddr  (b0.araddr),
    .i_axi_arvalid (b0.arvalid),
    .o_axi_arready (b0.arready),
    .o_axi_rdata   (b0.rdata),
    .o_axi_rvalid  (b0.rvalid),
    .o_axi_rresp   (b0.rresp),
    .i_axi_rready  (b0.rready)
  );

  ysyx_24110006_clint #(
    .BASE_ADDR (BASE),
    .TICK_DIV  (4)
  ) u_dut1 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_axi_araddr  (b1.araddr),
    .i_axi_arvalid (b1.arvalid),
    .o_axi_arready (b1.arready),
    .o_axi_rdata   (b1.rdata),
    .o_axi_rvalid  (b1.rvalid),
    .o_axi_rresp   (b1.rresp),
    .i_axi_rready  (b1.rready)
  );

  // cycles since reset release; reference time base for both instances
  int ncyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  clint_rd_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic f_arready(input int s);
    return (s == 0) ? b0.arready : b1.arready;
  endfunction
  function automatic logic f_rvalid(input int s);
    return (s == 0) ? b0.rvalid : b1.rvalid;
  endfunction
  function automatic logic [31:0] f_rdata(input int s);
    return (s == 0) ? b0.rdata : b1.rdata;
  endfunction
  function automatic logic [1:0] f_rresp(input int s);
    return (s == 0) ? b0.rresp : b1.rresp;
  endfunction

  task automatic drv(input int s, input logic v, input logic [31:0] a);
    if (s == 0) begin
      b0.arvalid = v;
      b0.araddr  = a;
    end else begin
      b1.arvalid = v;
      b1.araddr  = a;
    end
  endtask

  // one read with rready held high; model=1 derives lo-word data from ncyc
  task automatic rd(input int s, input logic [31:0] a, input bit model,
                    input clint_rd_t e, output logic [31:0] d);
    clint_rd_t x;
    clint_rd_t g;
    @(negedge clk);
    x = e;
    if (model) x.data = (s == 0) ? 32'(ncyc) : 32'(ncyc / 4);
    sb.push_back(x);
    chk("arready_idle", f_arready(s), 1'b1);
    drv(s, 1'b1, a);
    @(negedge clk);
    drv(s, 1'b0, 32'h0);
    chk("rvalid_next", f_rvalid(s), 1'b1);
    chk("arready_resp", f_arready(s), 1'b0);
    g = sb.pop_front();
    chk("rdata", f_rdata(s), g.data);
    chk("rresp", f_rresp(s), g.resp);
    d = f_rdata(s);
    @(negedge clk);
    chk("rvalid_drop", f_rvalid(s), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, da, db;
    clint_rd_t g;

    b0.arvalid = 1'b0; b0.araddr = '0; b0.rready = 1'b1;
    b1.arvalid = 1'b0; b1.araddr = '0; b1.rready = 1'b1;

    // reset state
    #12;
    chk("rst_arready0", b0.arready, 1'b0);
    chk("rst_rvalid0",  b0.rvalid,  1'b0);
    chk("rst_rdata0",   b0.rdata,   32'h0);
    chk("rst_rresp0",   b0.rresp,   RESP_OKAY);
    chk("rst_arready1", b1.arready, 1'b0);
    chk("rst_rvalid1",  b1.rvalid,  1'b0);
    repeat (3) @(posedge clk);
    #1 chk("rst_arready_edges", b0.arready, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arready_pre_edge", b0.arready, 1'b0);

    // read at cycle 10 after release returns exactly 10
    repeat (10) @(posedge clk);
    rd(0, BASE, 1'b0, rd_pack(32'd10, RESP_OKAY), d);

    rd(0, BASE, 1'b1, rd_pack(32'h0, RESP_OKAY), d);
    rd(0, BASE + 32'h4, 1'b0, rd_pack(32'h0, RESP_OKAY), d);
    rd(0, BASE + 32'h8, 1'b0, rd_pack(32'h0, RESP_SLVERR), d);
    rd(0, BASE, 1'b1, rd_pack(32'h0, RESP_OKAY), d);
    rd(1, BASE + 32'h3, 1'b0, rd_pack(32'h0, RESP_SLVERR), d);

    // TICK_DIV=4: two reads 40 cycles apart differ by 10
    rd(1, BASE, 1'b1, rd_pack(32'h0, RESP_OKAY), da);
    repeat (37) @(negedge clk);
    rd(1, BASE, 1'b1, rd_pack(32'h0, RESP_OKAY), db);
    chk("div4_delta", db - da, 32'd10);

    // rready stall: data held, AR ignored
    @(negedge clk);
    sb.push_back(rd_pack(32'(ncyc), RESP_OKAY));
    b0.rready = 1'b0;
    drv(0, 1'b1, BASE);
    @(negedge clk);
    drv(0, 1'b1, BASE + 32'h4);
    g = sb.pop_front();
    chk("stall_rdata0", b0.rdata, g.data);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", b0.rvalid, 1'b1);
      chk("stall_rdata", b0.rdata, g.data);
      chk("stall_rresp", b0.rresp, RESP_OKAY);
      chk("stall_arready", b0.arready, 1'b0);
    end
    b0.rready = 1'b1;
    drv(0, 1'b0, 32'h0);
    @(negedge clk);
    chk("stall_exit_rvalid", b0.rvalid, 1'b0);
    chk("stall_exit_arready", b0.arready, 1'b1);
    @(negedge clk);
    chk("stall_no_ghost", b0.rvalid, 1'b0);

    // low/high pair across a 32-bit carry, mtime forced at the timer output
    force u_dut0.w_mtime = 64'h0000_0000_FFFF_FFFF;
    rd(0, BASE, 1'b0, rd_pack(32'hFFFF_FFFF, RESP_OKAY), d);
    force u_dut0.w_mtime = 64'h0000_0001_0000_0002;
`ifdef CLINT_SNAPSHOT_EN
    rd(0, BASE + 32'h4, 1'b0, rd_pack(32'h0, RESP_OKAY), d);
`else
    rd(0, BASE + 32'h4, 1'b0, rd_pack(32'h1, RESP_OKAY), d);
`endif
    release u_dut0.w_mtime;

    // reset in the middle of a stalled response
    @(negedge clk);
    b0.rready = 1'b0;
    drv(0, 1'b1, BASE);
    @(negedge clk);
    drv(0, 1'b0, 32'h0);
    chk("mid_rvalid_pre", b0.rvalid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rvalid_rst", b0.rvalid, 1'b0);
    chk("mid_arready_rst", b0.arready, 1'b0);
    chk("mid_rdata_rst", b0.rdata, 32'h0);
    chk("mid_mtime_rst", u_dut0.w_mtime, 64'h0);
    b0.rready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_rvalid", b0.rvalid, 1'b0);
    rd(0, BASE, 1'b1, rd_pack(32'h0, RESP_OKAY), d);
    rd(1, BASE, 1'b1, rd_pack(32'h0, RESP_OKAY), d);

    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_clint.md
YSYX_24110006_CLINT -- requirements
Module: ysyx_24110006_clint

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0200_0000, byte address of mtime low word; high word at BASE_ADDR+4.
REQ-002 Parameter TICK_DIV, default 1, clock cycles per mtime increment; legal range 1..65535.
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_axi_araddr  input  32  read address from crossbar clint port.
REQ-006 i_axi_arvalid  input  1  read address valid.
REQ-007 o_axi_arready  output  1  read address accepted.
REQ-008 o_axi_rdata  output  32  read data.
REQ-009 o_axi_rvalid  output  1  read data valid.
REQ-010 o_axi_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-011 i_axi_rready  input  1  read data accepted by crossbar.

Function
REQ-012 mtime SHALL be a 64-bit counter incrementing by 1 once every TICK_DIV cycles, via prescaler counting 0..TICK_DIV-1.
REQ-013 TICK_DIV=1: mtime SHALL increment every cycle; prescaler logic degenerates to constant.
REQ-014 mtime SHALL wrap 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag or stall.
REQ-015 Read FSM SHALL have two states: IDLE (arready=1, rvalid=0) and RESP (arready=0, rvalid=1).
REQ-016 IDLE -> RESP on arvalid && arready; rdata/rresp registered in that same edge from address and current mtime value (1-cycle latency, rvalid asserted cycle after AR handshake).
REQ-017 RESP -> IDLE on rvalid && rready; no new AR accepted in the RESP cycle (max one read per two cycles).
REQ-018 rdata/rresp SHALL remain stable while rvalid && !rready; mtime keeps counting during stall.
REQ-019 araddr==BASE_ADDR -> rdata=mtime[31:0], OKAY; araddr==BASE_ADDR+4 -> rdata per REQ-026/027, OKAY.
REQ-020 Any other araddr -> rdata=32'h0, rresp=2'b10; FSM timing unchanged.
REQ-021 Increment and AR handshake in same edge: returned value SHALL be pre-increment mtime.
REQ-022 No write channel; block SHALL be read-only.

Reset
REQ-023 On i_rst_n low, asynchronously: mtime=0, prescaler=0, state=IDLE, o_axi_rvalid=0, o_axi_rdata=0, o_axi_rresp=2'b00, shadow=0.
REQ-024 o_axi_arready SHALL be 0 while i_rst_n low and 1 from first edge after release.
REQ-025 Reset during RESP SHALL drop rvalid immediately; in-flight read is discarded.

Configuration
REQ-026 With CLINT_SNAPSHOT_EN defined: read of low word SHALL latch mtime[63:32] into 32-bit shadow at same edge; high-word read returns shadow (atomic 64-bit pair read).
REQ-027 Without CLINT_SNAPSHOT_EN: no shadow register; high-word read returns live mtime[63:32] at AR handshake.

Structure
REQ-028 Package ysyx_24110006_clint_pkg SHALL hold: MTIME_LO_OFF=0, MTIME_HI_OFF=4, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, FSM state enum {IDLE, RESP}.
REQ-029 Sub-module ysyx_24110006_clint_timer SHALL contain prescaler and 64-bit mtime, parameter TICK_DIV, output mtime[63:0].
REQ-030 Top SHALL contain only AXI read FSM, address decode, shadow register.

Verification
REQ-031 TICK_DIV=1, release reset, read 0x0200_0000 at cycle 10 after release -> rdata=10 (+/- fixed pipeline offset documented in bench), OKAY, rvalid one cycle after handshake.
REQ-032 TICK_DIV=4, read low word twice 40 cycles apart -> values differ by 10.
REQ-033 Force mtime=64'h0000_0000_FFFF_FFFF, CLINT_SNAPSHOT_EN on, read low then high 3 cycles later -> 32'hFFFF_FFFF then 32'h0; without macro high -> 32'h1.
REQ-034 Read 0x0200_0008 -> rdata=0, rresp=2'b10; next read 0x0200_0000 -> OKAY.
REQ-035 Hold rready=0 for 5 cycles in RESP -> rdata constant, arready=0, arvalid ignored; rready=1 -> IDLE next cycle.
REQ-036 Assert i_rst_n=0 mid-RESP between edges -> rvalid=0 same instant, mtime=0 after release.
